// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: ALU/load arbitration, load-result queue, pending-load scoreboard
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   iAluValid/iAluAddr/iAluData     ALU result; held by upstream while oAluStall is high
//   oAluStall                       ALU result not accepted this cycle
//   iLdIssue/iLdIssueAddr           load issued to memory; marks its destination busy
//   iMemValid/iMemAddr/iMemData     returning load data; accepted only when oMemReady
//   oMemReady                       load-result queue has room
//   rf_we/WAddr/WData               registered register-file write port
//   oBusy                           pending-load scoreboard, bit n = register n

module wb_stage #(
    parameter int LDQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iAluValid,
    input  logic [4:0]  iAluAddr,
    input  logic [31:0] iAluData,
    output logic        oAluStall,
    input  logic        iLdIssue,
    input  logic [4:0]  iLdIssueAddr,
    input  logic        iMemValid,
    input  logic [4:0]  iMemAddr,
    input  logic [31:0] iMemData,
    output logic        oMemReady,
    output logic        rf_we,
    output logic [4:0]  WAddr,
    output logic [31:0] WData,
    output logic [31:0] oBusy
);

    localparam int CNT_W = $clog2(LDQ_DEPTH + 1);
    localparam int PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LDQ_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(LDQ_DEPTH - 1);

    logic [4:0]       qAddr [LDQ_DEPTH];
    logic [31:0]      qData [LDQ_DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] count;

    logic        aluAccept;
    logic        doPop;
    logic        doPush;
    logic [4:0]  headAddr;
    logic [31:0] headData;
    logic [31:0] setMask;
    logic [31:0] clearMask;

    // Both flags come straight from the count register so neither the ALU
    // nor the memory side ever sees a combinational path from its inputs.
    assign oMemReady = (count < FULL_COUNT);
    assign oAluStall = (count == FULL_COUNT);

    assign headAddr = qAddr[rdPtr];
    assign headData = qData[rdPtr];

    // ALU has priority unless the queue is full; a full queue forces a pop,
    // so the stall always clears the following cycle.
    assign aluAccept = iAluValid && !oAluStall;
    assign doPop     = !aluAccept && (count != '0);
    assign doPush    = iMemValid && oMemReady;

    // A pop's clear and an issue's set on the same bit resolve to set, since
    // the new load is still outstanding.
    assign setMask   = iLdIssue ? (32'd1 << iLdIssueAddr) : 32'd0;
    assign clearMask = doPop ? (32'd1 << headAddr) : 32'd0;

    // Queue storage is only read where count says an entry is valid, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            qAddr[wrPtr] <= iMemAddr;
            qData[wrPtr] <= iMemData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= (wrPtr == LAST_PTR) ? '0 : wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we <= 1'b0;
            WAddr <= '0;
            WData <= '0;
            oBusy <= '0;
        end else begin
            rf_we <= aluAccept || doPop;
            if (aluAccept) begin
                WAddr <= iAluAddr;
                WData <= iAluData;
            end else if (doPop) begin
                WAddr <= headAddr;
                WData <= headData;
            end
            oBusy <= (oBusy & ~clearMask) | setMask;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with a queue-based reference model

module tb_wb_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iAluValid = 1'b0;
    logic [4:0]  iAluAddr = '0;
    logic [31:0] iAluData = '0;
    logic        oAluStall;
    logic        iLdIssue = 1'b0;
    logic [4:0]  iLdIssueAddr = '0;
    logic        iMemValid = 1'b0;
    logic [4:0]  iMemAddr = '0;
    logic [31:0] iMemData = '0;
    logic        oMemReady;
    logic        rf_we;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic [31:0] oBusy;

    int checks = 0;
    int errors = 0;

    wb_stage #(.LDQ_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .iAluValid(iAluValid),
        .iAluAddr(iAluAddr),
        .iAluData(iAluData),
        .oAluStall(oAluStall),
        .iLdIssue(iLdIssue),
        .iLdIssueAddr(iLdIssueAddr),
        .iMemValid(iMemValid),
        .iMemAddr(iMemAddr),
        .iMemData(iMemData),
        .oMemReady(oMemReady),
        .rf_we(rf_we),
        .WAddr(WAddr),
        .WData(WData),
        .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: load results as a plain queue, write port and
    // scoreboard as the values the register file must observe.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    logic        mWe = 1'b0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;
    logic [31:0] mBusy = '0;
    logic        mFull;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                mWe = 1'b0;
                mAddr = '0;
                mData = '0;
                mBusy = '0;
            end else begin
                mFull = (q.size() == DEPTH);
                mWe = 1'b0;
                if (iAluValid && !mFull) begin
                    mWe = 1'b1;
                    mAddr = iAluAddr;
                    mData = iAluData;
                end else if (q.size() != 0) begin
                    e = q.pop_front();
                    mWe = 1'b1;
                    mAddr = e.a;
                    mData = e.d;
                    mBusy[e.a] = 1'b0;
                end
                if (iMemValid && !mFull) begin
                    e.a = iMemAddr;
                    e.d = iMemData;
                    q.push_back(e);
                end
                if (iLdIssue) mBusy[iLdIssueAddr] = 1'b1;
            end
            #1;
            chk("model_rf_we", {31'd0, rf_we}, {31'd0, mWe});
            chk("model_WAddr", {27'd0, WAddr}, {27'd0, mAddr});
            chk("model_WData", WData, mData);
            chk("model_oBusy", oBusy, mBusy);
            chk("model_oMemReady", {31'd0, oMemReady}, {31'd0, (q.size() < DEPTH)});
            chk("model_oAluStall", {31'd0, oAluStall}, {31'd0, (q.size() == DEPTH)});
        end
    end

    task automatic apply(input logic aV, input logic [4:0] aA, input logic [31:0] aD,
                         input logic lI, input logic [4:0] lA,
                         input logic mV, input logic [4:0] mA, input logic [31:0] mD);
        iAluValid = aV;
        iAluAddr = aA;
        iAluData = aD;
        iLdIssue = lI;
        iLdIssueAddr = lA;
        iMemValid = mV;
        iMemAddr = mA;
        iMemData = mD;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_oBusy", oBusy, 32'd0);
        chk("rst_oMemReady", {31'd0, oMemReady}, 32'd1);
        chk("rst_oAluStall", {31'd0, oAluStall}, 32'd0);
        #8 reset = 1'b0;
        @(posedge clk);
        #2;

        // ALU only
        apply(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("alu_we", {31'd0, rf_we}, 32'd1);
        chk("alu_addr", {27'd0, WAddr}, 32'd3);
        chk("alu_data", WData, 32'hDEADBEEF);
        chk("alu_busy", oBusy, 32'd0);
        idle();
        chk("alu_idle_we", {31'd0, rf_we}, 32'd0);
        chk("alu_idle_hold", WData, 32'hDEADBEEF);

        // Load round-trip
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
        chk("ld_busy_set", oBusy, 32'h00000080);
        idle();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678);
        chk("ld_no_bypass", {31'd0, rf_we}, 32'd0);
        idle();
        chk("ld_we", {31'd0, rf_we}, 32'd1);
        chk("ld_addr", {27'd0, WAddr}, 32'd7);
        chk("ld_data", WData, 32'h12345678);
        chk("ld_busy_clr", oBusy, 32'd0);

        // Contention: ALU every cycle plus two load returns
        apply(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 1'b1, 5'd10, 32'hA0);
        apply(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b1, 5'd11, 32'hB0);
        chk("cont_stall", {31'd0, oAluStall}, 32'd1);
        chk("cont_memrdy", {31'd0, oMemReady}, 32'd0);
        chk("cont_alu2", WData, 32'h22);
        apply(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("cont_head_addr", {27'd0, WAddr}, 32'd10);
        chk("cont_head_data", WData, 32'hA0);
        chk("cont_unstall", {31'd0, oAluStall}, 32'd0);
        apply(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("cont_alu_held", WData, 32'h33);
        idle();
        chk("cont_second_load", WData, 32'hB0);
        idle();
        chk("cont_drained", {31'd0, rf_we}, 32'd0);

        // Set/clear collision on reg 5
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h55);
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
        chk("coll_write", WData, 32'h55);
        chk("coll_busy", oBusy, 32'h00000020);
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h56);
        idle();
        chk("coll_cleared", oBusy, 32'd0);

        // Reset mid-operation with two queued entries
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b1, 5'd20, 32'hC0);
        apply(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1, 5'd21, 32'hC1);
        chk("pre_rst_busy", oBusy, 32'h00000180);
        chk("pre_rst_stall", {31'd0, oAluStall}, 32'd1);
        iAluValid = 1'b0;
        iMemValid = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("arst_we", {31'd0, rf_we}, 32'd0);
        chk("arst_addr", {27'd0, WAddr}, 32'd0);
        chk("arst_data", WData, 32'd0);
        chk("arst_busy", oBusy, 32'd0);
        chk("arst_memrdy", {31'd0, oMemReady}, 32'd1);
        chk("arst_stall", {31'd0, oAluStall}, 32'd0);
        iAluValid = 1'b1;
        iMemValid = 1'b1;
        iLdIssue = 1'b1;
        iLdIssueAddr = 5'd9;
        @(posedge clk);
        #2;
        chk("rst_hold_we", {31'd0, rf_we}, 32'd0);
        chk("rst_hold_busy", oBusy, 32'd0);
        iAluValid = 1'b0;
        iMemValid = 1'b0;
        iLdIssue = 1'b0;
        #3 reset = 1'b0;
        @(posedge clk);
        #2;
        idle();
        chk("post_rst_no_stale", {31'd0, rf_we}, 32'd0);
        chk("post_rst_memrdy", {31'd0, oMemReady}, 32'd1);

        // Register 0 is written like any other
        apply(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("r0_we", {31'd0, rf_we}, 32'd1);
        chk("r0_addr", {27'd0, WAddr}, 32'd0);
        chk("r0_data", WData, 32'hFFFFFFFF);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter LDQ_DEPTH, default 2, depth of the load-result queue; legal values 2..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iAluValid  input  1  ALU result present this cycle.
REQ-005 SHALL have port iAluAddr  input  5  ALU destination register.
REQ-006 SHALL have port iAluData  input  32  ALU result.
REQ-007 SHALL have port oAluStall  output  1  ALU result not accepted; upstream holds iAlu* stable.
REQ-008 SHALL have port iLdIssue  input  1  load issued to memory this cycle.
REQ-009 SHALL have port iLdIssueAddr  input  5  destination register of the issued load.
REQ-010 SHALL have port iMemValid  input  1  load data returning from memory.
REQ-011 SHALL have port iMemAddr  input  5  destination register of returning load.
REQ-012 SHALL have port iMemData  input  32  returning load data.
REQ-013 SHALL have port oMemReady  output  1  queue can accept a load result this cycle.
REQ-014 SHALL have port rf_we  output  1  register-file write enable.
REQ-015 SHALL have port WAddr  output  5  register-file write address.
REQ-016 SHALL have port WData  output  32  register-file write data.
REQ-017 SHALL have port oBusy  output  32  per-register pending-load scoreboard, bit n = register n.

Function
REQ-018 SHALL hold load results in an in-order FIFO of LDQ_DEPTH entries (5-bit addr + 32-bit data); count width covers 0..LDQ_DEPTH.
REQ-019 SHALL push iMemAddr/iMemData when iMemValid && oMemReady; iMemValid with oMemReady low SHALL be ignored (responder holds).
REQ-020 SHALL drive oMemReady = (count < LDQ_DEPTH), from registered state only; no combinational path from any input.
REQ-021 SHALL drive oAluStall = (count == LDQ_DEPTH), from registered state only.
REQ-022 SHALL arbitrate one write per cycle: ALU accepted (iAluValid && !oAluStall) wins; else FIFO non-empty pops head; else no write.
REQ-023 SHALL register outputs: the selected write appears on rf_we/WAddr/WData at the next rising edge, i.e. one-cycle latency from acceptance/pop.
REQ-024 SHALL deassert rf_we in cycles with no selected write; WAddr/WData hold last value then.
REQ-025 SHALL, when oAluStall is high, always pop the FIFO head that cycle, guaranteeing progress.
REQ-026 SHALL allow push and pop in the same cycle; count unchanged; pushed entry written behind remaining entries; order strictly preserved; pointers wrap modulo LDQ_DEPTH.
REQ-027 SHALL not bypass: a load result reaches rf_we no earlier than two edges after acceptance.
REQ-028 SHALL set oBusy[iLdIssueAddr] at the edge where iLdIssue is high.
REQ-029 SHALL clear oBusy[a] at the edge where a popped load result with address a is registered onto rf_we.
REQ-030 SHALL, on same-edge set and clear of the same bit, leave it set (set wins).
REQ-031 SHALL leave oBusy unaffected by ALU writes; WAW/RAW hazard stalling is the decode stage's duty.
REQ-032 SHALL write register 0 like any other register; no address filtering.

Reset
REQ-033 SHALL, on reset assertion, immediately drive rf_we=0, WAddr=0, WData=0, oBusy=0, count=0, pointers=0, hence oMemReady=1, oAluStall=0.
REQ-034 SHALL discard queued load results on reset, including mid-operation; inputs ignored while reset high.
REQ-035 SHALL accept inputs from the first rising edge after reset deassertion.

Verification
REQ-036 ALU only: iAluValid=1, addr 3, data 0xDEADBEEF at edge k -> rf_we=1, WAddr=3, WData=0xDEADBEEF after edge k+1, oBusy unchanged.
REQ-037 Load round-trip: iLdIssue addr 7 -> oBusy[7]=1; later iMemValid addr 7 data 0x12345678 with no ALU -> write after 2nd edge, oBusy[7]=0 at that same edge.
REQ-038 Contention: ALU valid every cycle plus two load returns -> count reaches 2, oAluStall=1, oMemReady=0; next cycle writes queue head, ALU write held then committed; no write lost, load order preserved.
REQ-039 Set/clear collision: load for reg 5 committing while iLdIssue addr 5 same cycle -> oBusy[5] stays 1.
REQ-040 Reset mid-operation: queue holds 2 entries, oBusy=0x00000180, reset pulsed asynchronously -> all outputs zero immediately, oMemReady=1, no further writes of stale entries.
